// File: rtl/llc_input_arbiter.sv
// llc_input_arbiter: N-channel priority decoder at the front of the LLC pipeline.
// Picks one resume source or one input channel per decode cycle, honouring
// recall gating, per-channel blocking and a stalled-request replay queue.
// Optional feature macro: LLC_ARB_AGING_EN (starvation promotion by age).
module llc_input_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int NUM_RES      = 2,
  parameter int RSP_CH       = 1,
  parameter int REPLAY_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              decode_en,
  input  logic [NUM_CH-1:0]                 ch_valid,
  input  logic [NUM_CH-1:0]                 ch_block,
  input  logic [NUM_RES-1:0]                res_valid,
  input  logic                              recall_pending,
  input  logic                              recall_valid,
  input  logic                              replay_push,
  input  logic [$clog2(NUM_CH)-1:0]         replay_push_ch,
  output logic [NUM_CH-1:0]                 do_get,
  output logic                              replay_pop,
  output logic [NUM_CH-1:0]                 grant,
  output logic                              grant_replay,
  output logic [NUM_RES-1:0]                res_grant,
  output logic                              look,
  output logic [$clog2(REPLAY_DEPTH+1)-1:0] replay_count,
  output logic                              replay_full,
  output logic                              err_overflow
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(REPLAY_DEPTH + 1);
  localparam int PTR_W = (REPLAY_DEPTH > 1) ? $clog2(REPLAY_DEPTH) : 1;

  // Elaboration-time parameter sanity checks
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("llc_input_arbiter: NUM_CH must be at least 2");
  end
  if (RSP_CH >= NUM_CH) begin : g_bad_rsp_ch
    $error("llc_input_arbiter: RSP_CH must be below NUM_CH");
  end
  if (REPLAY_DEPTH < 1) begin : g_bad_depth
    $error("llc_input_arbiter: REPLAY_DEPTH must be at least 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("llc_input_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic [CH_W-1:0]   rq_mem [REPLAY_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              head_valid;
  logic [CH_W-1:0]   head_ch;
  logic              push_ok;

  logic [NUM_CH-1:0]  elig;
  logic [NUM_CH-1:0]  grant_nxt;
  logic [NUM_RES-1:0] res_nxt;
  logic [CH_W-1:0]    win_idx;
  logic               found;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REPLAY_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign replay_count = count_q;
  assign replay_full  = (count_q == CNT_W'(REPLAY_DEPTH));
  assign head_valid   = (count_q != '0);
  assign head_ch      = rq_mem[rd_ptr];
  assign push_ok      = replay_push && !replay_full;

`ifdef LLC_ARB_AGING_EN
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [AGE_W-1:0]  age_q [1:NUM_CH-1];
  logic [NUM_CH-1:0] aged;

  // Flag channels whose wait has reached the starvation limit
  always_comb begin
    aged = '0;
    for (int unsigned i = 1; i < NUM_CH; i++) begin
      aged[i] = (age_q[i] == AGE_W'(STARVE_LIMIT));
    end
  end

  // Age counters: count eligible-but-losing decode cycles, clear otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 1; i < NUM_CH; i++) age_q[i] <= '0;
    end else if (decode_en) begin
      for (int unsigned i = 1; i < NUM_CH; i++) begin
        if (elig[i] && !grant_nxt[i]) begin
          if (age_q[i] != AGE_W'(STARVE_LIMIT)) age_q[i] <= age_q[i] + 1'b1;
        end else begin
          age_q[i] <= '0;
        end
      end
    end
  end
`endif

  // Channel eligibility: unblocked and either fresh input or the replay head
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      elig[i] = !ch_block[i] &&
                (ch_valid[i] || (head_valid && head_ch == CH_W'(i)));
    end
  end

  // Priority selection; the replay head beats fresh input for the same channel
  always_comb begin
    do_get     = '0;
    replay_pop = 1'b0;
    grant_nxt  = '0;
    res_nxt    = '0;
    win_idx    = '0;
    found      = 1'b0;
    if (decode_en) begin
      if (recall_pending) begin
        if (!recall_valid && ch_valid[RSP_CH] && !ch_block[RSP_CH]) begin
          grant_nxt[RSP_CH] = 1'b1;
          do_get[RSP_CH]    = 1'b1;
        end
      end else if (|res_valid) begin
        for (int unsigned i = 0; i < NUM_RES; i++) begin
          if (res_valid[i] && !found) begin
            res_nxt[i] = 1'b1;
            found      = 1'b1;
          end
        end
      end else begin
`ifdef LLC_ARB_AGING_EN
        for (int unsigned i = 1; i < NUM_CH; i++) begin
          if (elig[i] && aged[i] && !found) begin
            win_idx = CH_W'(i);
            found   = 1'b1;
          end
        end
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (elig[i] && !found) begin
            win_idx = CH_W'(i);
            found   = 1'b1;
          end
        end
        if (found) begin
          grant_nxt[win_idx] = 1'b1;
          if (head_valid && head_ch == win_idx) replay_pop = 1'b1;
          else                                  do_get[win_idx] = 1'b1;
        end
      end
    end
  end

  // Registered grant outputs, updated only on decode cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      res_grant    <= '0;
      grant_replay <= 1'b0;
      look         <= 1'b0;
    end else if (decode_en) begin
      grant        <= grant_nxt;
      res_grant    <= res_nxt;
      grant_replay <= replay_pop;
      look         <= (|grant_nxt) | (|res_nxt);
    end
  end

  // Replay queue storage; dropped pushes never touch the array
  always_ff @(posedge clk) begin
    if (push_ok) rq_mem[wr_ptr] <= replay_push_ch;
  end

  // Replay queue pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok)    wr_ptr <= ptr_inc(wr_ptr);
      if (replay_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, replay_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (replay_push && replay_full) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Testbench for llc_input_arbiter (default parameters). Directed steps with a
// scoreboard queue for the registered grant outputs. Define LLC_ARB_AGING_EN
// for both RTL and bench to exercise starvation promotion.
module tb_llc_input_arbiter;

  logic       clk;
  logic       rst;
  logic       decode_en;
  logic [3:0] ch_valid;
  logic [3:0] ch_block;
  logic [1:0] res_valid;
  logic       recall_pending;
  logic       recall_valid;
  logic       replay_push;
  logic [1:0] replay_push_ch;
  logic [3:0] do_get;
  logic       replay_pop;
  logic [3:0] grant;
  logic       grant_replay;
  logic [1:0] res_grant;
  logic       look;
  logic [2:0] replay_count;
  logic       replay_full;
  logic       err_overflow;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] res_grant;
    logic       grant_replay;
    logic       look;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  llc_input_arbiter #(
    .NUM_CH(4), .NUM_RES(2), .RSP_CH(1), .REPLAY_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .decode_en(decode_en), .ch_valid(ch_valid),
    .ch_block(ch_block), .res_valid(res_valid), .recall_pending(recall_pending),
    .recall_valid(recall_valid), .replay_push(replay_push),
    .replay_push_ch(replay_push_ch), .do_get(do_get), .replay_pop(replay_pop),
    .grant(grant), .grant_replay(grant_replay), .res_grant(res_grant),
    .look(look), .replay_count(replay_count), .replay_full(replay_full),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check combinational outputs, queue the expected registered state, clock, compare
  task automatic step(input string tag, input logic [3:0] e_get, input logic e_pop,
                      input logic [3:0] e_g, input logic [1:0] e_r, input logic e_gr);
    exp_t e;
    exp_t got;
    #1;
    chk({tag, ".do_get"}, 32'(do_get), 32'(e_get));
    chk({tag, ".replay_pop"}, 32'(replay_pop), 32'(e_pop));
    e.grant        = e_g;
    e.res_grant    = e_r;
    e.grant_replay = e_gr;
    e.look         = (|e_g) | (|e_r);
    sb.push_back(e);
    tick();
    got = {grant, res_grant, grant_replay, look};
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, ".regs"}, 32'(got), 32'(e));
    end
  endtask

  initial begin
    // Reset with every input driven high
    rst = 1'b1; decode_en = 1'b1; ch_valid = '1; ch_block = '1; res_valid = '1;
    recall_pending = 1'b1; recall_valid = 1'b1; replay_push = 1'b1; replay_push_ch = '1;
    tick();
    tick();
    chk("rst.grant", 32'(grant), 32'(0));
    chk("rst.res_grant", 32'(res_grant), 32'(0));
    chk("rst.grant_replay", 32'(grant_replay), 32'(0));
    chk("rst.look", 32'(look), 32'(0));
    chk("rst.count", 32'(replay_count), 32'(0));
    chk("rst.full", 32'(replay_full), 32'(0));
    chk("rst.err", 32'(err_overflow), 32'(0));
    chk("rst.do_get", 32'(do_get), 32'(0));
    chk("rst.replay_pop", 32'(replay_pop), 32'(0));
    rst = 1'b0; decode_en = 1'b0; ch_valid = '0; ch_block = '0; res_valid = '0;
    recall_pending = 1'b0; recall_valid = 1'b0; replay_push = 1'b0; replay_push_ch = '0;
    tick();

    // Strict priority and blocking
    decode_en = 1'b1; ch_valid = 4'b1110;
    step("prio", 4'b0010, 1'b0, 4'b0010, 2'b00, 1'b0);
    ch_block = 4'b0010;
    step("block", 4'b0100, 1'b0, 4'b0100, 2'b00, 1'b0);
    decode_en = 1'b0; ch_valid = 4'b1111; ch_block = 4'b0000;
    step("hold", 4'b0000, 1'b0, 4'b0100, 2'b00, 1'b0);

    // Recall gating
    decode_en = 1'b1; recall_pending = 1'b1;
    step("recall", 4'b0010, 1'b0, 4'b0010, 2'b00, 1'b0);
    ch_block = 4'b0010;
    step("recall_blk", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
    ch_block = 4'b0000;
    step("recall2", 4'b0010, 1'b0, 4'b0010, 2'b00, 1'b0);
    recall_valid = 1'b1;
    step("recall_rsp", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);

    // Resume sources outrank channels
    recall_pending = 1'b0; recall_valid = 1'b0; res_valid = 2'b10; ch_valid = 4'b0001;
    step("resume", 4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0);
    res_valid = 2'b11;
    step("resume_lo", 4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0);
    res_valid = 2'b00; ch_valid = 4'b0000;
    step("idle", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);

    // Fill the replay queue with channel 2, then overflow it
    decode_en = 1'b0; replay_push = 1'b1; replay_push_ch = 2'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fill.count", 32'(replay_count), 32'(k + 1));
      chk("fill.full", 32'(replay_full), 32'(k == 3));
    end
    chk("fill.err", 32'(err_overflow), 32'(0));
    tick();
    chk("ovf.count", 32'(replay_count), 32'(4));
    chk("ovf.full", 32'(replay_full), 32'(1));
    chk("ovf.err", 32'(err_overflow), 32'(1));
    replay_push = 1'b0;

    // Replay head beats fresh input for the same channel
    decode_en = 1'b1; ch_valid = 4'b0100;
    step("replay_pop", 4'b0000, 1'b1, 4'b0100, 2'b00, 1'b1);
    chk("replay_pop.count", 32'(replay_count), 32'(3));
    ch_valid = 4'b0001;
    step("fresh_hi", 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0);
    chk("fresh_hi.count", 32'(replay_count), 32'(3));
    chk("fresh_hi.full", 32'(replay_full), 32'(0));
    ch_valid = 4'b0000;
    step("replay_only", 4'b0000, 1'b1, 4'b0100, 2'b00, 1'b1);
    chk("replay_only.count", 32'(replay_count), 32'(2));
    ch_block = 4'b0100;
    step("replay_blocked", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("replay_blocked.count", 32'(replay_count), 32'(2));
    ch_block = 4'b0000; replay_push = 1'b1; replay_push_ch = 2'd1;
    step("push_pop", 4'b0000, 1'b1, 4'b0100, 2'b00, 1'b1);
    chk("push_pop.count", 32'(replay_count), 32'(2));
    replay_push = 1'b0;
    step("drain_a", 4'b0000, 1'b1, 4'b0100, 2'b00, 1'b1);
    chk("drain_a.count", 32'(replay_count), 32'(1));
    step("drain_b", 4'b0000, 1'b1, 4'b0010, 2'b00, 1'b1);
    chk("drain_b.count", 32'(replay_count), 32'(0));
    replay_push = 1'b1; replay_push_ch = 2'd3;
    step("push_empty", 4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0);
    chk("push_empty.count", 32'(replay_count), 32'(1));
    replay_push = 1'b0;
    step("pop_new", 4'b0000, 1'b1, 4'b1000, 2'b00, 1'b1);
    chk("pop_new.count", 32'(replay_count), 32'(0));
    chk("sticky.err", 32'(err_overflow), 32'(1));

    // Reset clears the sticky overflow flag
    decode_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2.err", 32'(err_overflow), 32'(0));
    chk("rst2.grant", 32'(grant), 32'(0));

    // Long contention between channel 0 and channel 3
    decode_en = 1'b1; ch_valid = 4'b1001;
`ifdef LLC_ARB_AGING_EN
    for (int k = 0; k < 8; k++) step("age_ch0", 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0);
    step("age_ch3", 4'b1000, 1'b0, 4'b1000, 2'b00, 1'b0);
    step("age_back", 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0);
`else
    for (int k = 0; k < 10; k++) step("strict_ch0", 4'b0001, 1'b0, 4'b0001, 2'b00, 1'b0);
`endif
    decode_en = 1'b0; ch_valid = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
- Parametrised N-channel priority decoder at the front of the LLC pipeline.
- Each decode cycle it selects one resume source or one input channel: reset, response, request, DMA request, and so on.
- Selection honours recall gating, per-channel blocking and a stalled-request replay queue.
- It emits a dequeue strobe and a registered one-hot grant, which the LLC FSM consumes.

Parameters:
- NUM_CH, 4: number of input channels; index 0 has the highest priority.
- NUM_RES, 2: number of resume sources (e.g. rst, flush); these rank above all channels.
- RSP_CH, 1: the only channel eligible while a recall is outstanding.
- REPLAY_DEPTH, 4: number of entries in the stalled-request replay queue; must be at least 1.
- STARVE_LIMIT, 8: age threshold for the aging promotion feature; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- decode_en  in  1  evaluate and update grant this cycle
- ch_valid  in  NUM_CH  channel has a pending message
- ch_block  in  NUM_CH  channel currently not eligible (req_stall, dma pending, ...)
- res_valid  in  NUM_RES  resume source pending
- recall_pending  in  1  recall outstanding
- recall_valid  in  1  recall response received
- replay_push  in  1  enqueue a stalled request
- replay_push_ch  in  $clog2(NUM_CH)  channel id of the pushed request
- do_get  out  NUM_CH  combinational dequeue strobe to the input channel (one-hot or zero)
- replay_pop  out  1  combinational: replay head consumed this cycle
- grant  out  NUM_CH  registered one-hot channel grant
- grant_replay  out  1  registered: the grant came from the replay queue
- res_grant  out  NUM_RES  registered one-hot resume grant
- look  out  1  registered: OR of grant and res_grant
- replay_count  out  $clog2(REPLAY_DEPTH+1)  queue occupancy
- replay_full  out  1  replay_count equals REPLAY_DEPTH
- err_overflow  out  1  sticky: a push arrived while the queue was full

Behaviour:
- Clocking and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: while rst=1 at a clock edge, all registered outputs, the queue pointers, the count, err_overflow and the age counters go to 0.
- decode_en=0:
  - do_get and replay_pop are 0.
  - grant, res_grant, grant_replay and look hold their values.
  - The replay queue still accepts pushes.
- Selection when decode_en=1 (combinational; result registered at the next edge, so latency is 1 cycle). The first matching rule wins:
  1. recall_pending=1 and recall_valid=0: only RSP_CH may win, and only if ch_valid[RSP_CH]=1 and ch_block[RSP_CH]=0. Otherwise nothing is granted.
  2. recall_pending=1 and recall_valid=1: nothing is granted; the grant outputs are cleared.
  3. Any res_valid set: the lowest set index is granted in res_grant. No do_get.
  4. A channel is eligible if ch_block[i]=0 and either ch_valid[i]=1 or the replay head is channel i. Among eligible channels, the lowest index wins.
- Replay versus fresh input:
  - If the winning channel matches the non-empty replay head, the head wins over fresh input.
  - In that case replay_pop=1, grant_replay=1 and do_get=0.
  - Otherwise do_get[i]=1 and grant_replay=0.
- No winner: when decode_en=1 and nothing wins, all grants are cleared to 0 at the next edge.
- Grant encoding: at most one bit is set across grant and res_grant together.
- Replay queue: FIFO of channel ids.
  - Push and pop in the same cycle is legal, and the count is unchanged.
  - A pop only sees the pre-cycle head, so a push into an empty queue cannot be popped in the same cycle.
  - A push while full is dropped, the count is unchanged, and err_overflow is set until reset.
  - Pointers wrap modulo REPLAY_DEPTH; with a non-power-of-two depth they wrap at REPLAY_DEPTH-1 to 0.

Optional Feature:
- Macro: LLC_ARB_AGING_EN.
- When defined:
  - Each channel i>0 has an age counter, $clog2(STARVE_LIMIT+1) bits wide.
  - On each decode_en cycle where channel i is eligible but not granted, its counter increments, saturating at STARVE_LIMIT.
  - The counter clears when channel i is granted or becomes ineligible.
  - A channel whose counter equals STARVE_LIMIT outranks all non-aged channels in rule 4, but not rules 1-3. If several are aged, the lowest index wins.
- When not defined: no counters exist and priority is strictly by index.

Test Plan:
- Reset behaviour: assert rst for 2 cycles with all inputs at 1 → all outputs are 0, replay_count=0, err_overflow=0.
- Strict priority: decode_en=1, ch_valid=4'b1110, ch_block=0 → do_get=4'b0010 that cycle; grant=4'b0010 and look=1 the next cycle.
- Recall gating: recall_pending=1, recall_valid=0, ch_valid=4'b1111 → only do_get[1]=1. Then set recall_valid=1 → do_get=0, and grant=0 the next cycle.
- Resume priority: res_valid=2'b10 with ch_valid=4'b0001 → res_grant=2'b10 and do_get=0.
- Replay queue:
  - Push ch 2 four times, then push once more → replay_full=1, err_overflow=1, count stays 4.
  - Then decode with ch_valid[2]=1 → replay_pop=1, grant_replay=1, do_get=0, count becomes 3.
- Aging (LLC_ARB_AGING_EN, STARVE_LIMIT=8): hold ch_valid=4'b1001 → ch 0 wins for 8 decode cycles, ch 3 wins on the 9th, then ch 0 wins again.
